// File: rtl/split_adder_seq_ctrl.sv
// Multi-cycle wide adder. A single segmented adder round is reused. Round 0
// adds the operands segment by segment. Each later round feeds the pending
// segment carries back in at the LSB of the next segment and adds again. The
// operation finishes when no carries remain pending.
// The block has valid/ready handshakes on both sides and holds one operation
// at a time.

// One adder round. Every SS-bit segment is added independently. The carry out
// of each segment is reported and is not propagated to the next segment.
// i_cin feeds segment 0 only. If IO%SS != 0, the top segment is narrower.
module split_adder_round #(
  parameter int IO      = 512,
  parameter int SS      = 4,
  parameter int N_PARTS = IO/SS + ((IO%SS) != 0 ? 1 : 0)
) (
  input  logic [IO-1:0]      i_x,
  input  logic [IO-1:0]      i_y,
  input  logic               i_cin,
  output logic [IO-1:0]      o_s,
  output logic [N_PARTS-1:0] o_c
);

  for (genvar k = 0; k < N_PARTS; k++) begin : g_seg
    localparam int LO = k*SS;
    localparam int HI = ((k+1)*SS > IO) ? IO-1 : (k+1)*SS-1;
    localparam int W  = HI-LO+1;

    logic         w_cin_seg;
    logic [W:0]   w_acc;

    assign w_cin_seg = (k == 0) ? i_cin : 1'b0;
    assign w_acc     = {1'b0, i_x[HI:LO]} + {1'b0, i_y[HI:LO]} + {{W{1'b0}}, w_cin_seg};
    assign o_s[HI:LO] = w_acc[W-1:0];
    assign o_c[k]     = w_acc[W];
  end

endmodule

module split_adder_seq_ctrl #(
  parameter int IO = 512,
  parameter int SS = (($clog2(IO) >> 2) > 0) ? (1 << ($clog2(IO) >> 2))
                                             : (1 << ($clog2(IO) >> 1))
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [IO-1:0]                               a,
  input  logic [IO-1:0]                               b,
  input  logic                                        cin,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [IO-1:0]                               sum,
  output logic                                        cout,
  output logic [$clog2(IO/SS + ((IO%SS) != 0 ? 1 : 0) + 1)-1:0] rounds,
  output logic                                        busy
);

  localparam int N_PARTS = IO/SS + ((IO%SS) != 0 ? 1 : 0);
  localparam int RW      = $clog2(N_PARTS+1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_PROP, S_DONE} state_t;

  state_t             r_state;
  logic [IO-1:0]      r_op_a;
  logic [IO-1:0]      r_op_b;
  logic               r_cin;
  logic [IO-1:0]      r_sum;
  logic               r_cout;
  logic [RW-1:0]      r_rounds;
  logic [N_PARTS-1:0] r_p;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [IO-1:0]      w_inj;
  logic [IO-1:0]      w_x;
  logic [IO-1:0]      w_y;
  logic [IO-1:0]      w_s;
  logic [N_PARTS-1:0] w_c;
  logic               w_p_lsb;
  logic [N_PARTS-1:0] w_p_next;

  // Place each pending carry at the LSB of the segment that must absorb it.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_inj = '0;
    for (int k = 0; k < N_PARTS; k++) begin
      w_inj[k*SS] = r_p[k];
    end
  end

  // Round 0 adds the captured operands. Later rounds add the injected carries to the partial sum.
  always_comb begin
    w_x = r_sum;
    w_y = w_inj;
    if (r_state == S_ADD) begin
      w_x = r_op_a;
      w_y = r_op_b;
    end
  end

  split_adder_round #(
    .IO      (IO),
    .SS      (SS),
    .N_PARTS (N_PARTS)
  ) u_round (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_cin (1'b0),
    .o_s   (w_s),
    .o_c   (w_c)
  );

  // Segment k's carry becomes pending for segment k+1. In round 0, the external
  // carry-in is pending for segment 0. The top carry leaves as cout.
  assign w_p_lsb  = (r_state == S_ADD) & r_cin;
  assign w_p_next = (w_c << 1) | N_PARTS'(w_p_lsb);

  // Sequencer: accept, round 0, propagate rounds until no carry is pending, then hold the result.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; rst_n overrides every handshake.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_cin       <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_rounds    <= '0;
      r_p         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_a     <= a;
            r_op_b     <= b;
            r_cin      <= cin;
            r_rounds   <= '0;
            r_cout     <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum  <= w_s;
          r_cout <= w_c[N_PARTS-1];
          r_p    <= w_p_next;
          if (w_p_next != '0) begin
            r_state <= S_PROP;
          end else begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_PROP: begin
          r_sum    <= w_s;
          r_cout   <= r_cout | w_c[N_PARTS-1];
          r_p      <= w_p_next;
          r_rounds <= r_rounds + RW'(1);
          if (w_p_next == '0) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // in_valid is ignored here, even in the same cycle as the result handshake.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign rounds    = r_rounds;

endmodule

// File: tb/tb_split_adder_seq_ctrl.sv
// Directed bench for split_adder_seq_ctrl. A 16-bit instance (SS=4) runs
// hand-computed vectors, handshake stalls and a mid-operation reset. A
// default 512-bit instance runs a worst-case carry chain and random operands
// against a plain a+b+cin reference. Latency is counted in clock edges,
// counting the accepting edge as the first one.
module tb_split_adder_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout, s_busy;
  logic [15:0] s_a, s_b, s_sum;
  logic [2:0]  s_rounds;

  // 512-bit instance
  logic         b_in_valid, b_in_ready, b_cin, b_out_valid, b_out_ready, b_cout, b_busy;
  logic [511:0] b_a, b_b, b_sum;
  logic [7:0]   b_rounds;

  int n_total = 0;
  int n_bad   = 0;

  split_adder_seq_ctrl #(.IO(16), .SS(4)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .a         (s_a),
    .b         (s_b),
    .cin       (s_cin),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .sum       (s_sum),
    .cout      (s_cout),
    .rounds    (s_rounds),
    .busy      (s_busy)
  );

  split_adder_seq_ctrl u_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .a         (b_a),
    .b         (b_b),
    .cin       (b_cin),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .sum       (b_sum),
    .cout      (b_cout),
    .rounds    (b_rounds),
    .busy      (b_busy)
  );

  task automatic check(input string tag, input logic [519:0] got, input logic [519:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One op on the 16-bit instance. Calls start and end at posedge+1.
  // hold: DONE cycles with out_ready=0 while in_valid is pulsed.
  // collide: in_valid is high in the cycle of the result handshake.
  task automatic small_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] es, input logic ec,
                          input int er, input int hold, input logic collide);
    int edges;
    s_a = a; s_b = b; s_cin = cin; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    edges = 1;
    check({name, ".busy"}, s_busy, 1'b1);
    while (!s_out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, ".latency"}, edges, 2 + er);
    check({name, ".sum"}, s_sum, es);
    check({name, ".cout"}, s_cout, ec);
    check({name, ".rounds"}, s_rounds, er);
    check({name, ".in_ready_done"}, s_in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      s_in_valid = i[0];
      s_a = 16'h1234;
      @(posedge clk); #1;
      check({name, ".hold_valid"}, s_out_valid, 1'b1);
      check({name, ".hold_sum"}, {s_cout, s_sum, s_rounds}, {ec, es, er[2:0]});
      check({name, ".hold_in_ready"}, s_in_ready, 1'b0);
    end
    s_in_valid  = collide;
    s_a         = 16'h5555;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    s_in_valid  = 1'b0;
    check({name, ".out_valid_after"}, s_out_valid, 1'b0);
    check({name, ".in_ready_after"}, s_in_ready, 1'b1);
    check({name, ".busy_after"}, s_busy, 1'b0);
  endtask

  // One op on the 512-bit instance with a random out_ready stall.
  // exp_rounds < 0 skips the exact round-count comparison.
  task automatic big_op(input string name, input logic [511:0] a, input logic [511:0] b,
                        input logic cin, input int exp_rounds);
    logic [512:0] ref_sum;
    logic [520:0] held;
    int edges;
    int stalls;
    logic rdy;
    logic done;
    ref_sum = {1'b0, a} + {1'b0, b} + 513'(cin);
    b_a = a; b_b = b; b_cin = cin; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    edges = 1;
    while (!b_out_valid && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, ".out_valid"}, b_out_valid, 1'b1);
    check({name, ".sum"}, {b_cout, b_sum}, ref_sum);
    check({name, ".rounds_le"}, (b_rounds <= 8'd128), 1'b1);
    check({name, ".latency"}, edges, 2 + int'(b_rounds));
    if (exp_rounds >= 0) check({name, ".rounds"}, b_rounds, exp_rounds);
    held   = {b_cout, b_sum, b_rounds};
    done   = 1'b0;
    stalls = 0;
    while (!done) begin
      rdy = (stalls >= 4) ? 1'b1 : 1'(($urandom_range(0, 1)));
      b_out_ready = rdy;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      if (rdy) done = 1'b1;
      else begin
        stalls++;
        check({name, ".stall_hold"}, {b_out_valid, b_cout, b_sum, b_rounds}, {1'b1, held});
      end
    end
    check({name, ".released"}, {b_out_valid, b_in_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ov_seen;
    logic [511:0] ra, rb;
    s_in_valid = 0; s_out_ready = 0; s_a = 0; s_b = 0; s_cin = 0;
    b_in_valid = 0; b_out_ready = 0; b_a = 0; b_b = 0; b_cin = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset.in_ready", s_in_ready, 1'b1);
    check("reset.outs", {s_out_valid, s_busy, s_cout, s_sum, s_rounds}, '0);
    check("reset.big", {b_in_ready, b_out_valid, b_busy}, 3'b100);
    rst_n = 1'b1;
    @(posedge clk); #1;

    small_op("add_simple", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 0, 0, 1'b0);
    small_op("full_chain", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4, 0, 1'b1);
    small_op("two_rounds", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 2, 0, 1'b0);
    small_op("stall_done", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4, 5, 1'b0);
    small_op("cout_round0", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0, 0, 1'b0);
    small_op("three_rounds", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 3, 0, 1'b0);

    // Reset while the full-chain op is in its second propagate round.
    s_a = 16'hFFFF; s_b = 16'h0000; s_cin = 1'b1; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst.pre_rounds", s_rounds, 3'd1);
    check("midrst.pre_busy", s_busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst.in_ready", s_in_ready, 1'b1);
    check("midrst.outs", {s_out_valid, s_busy, s_cout, s_sum, s_rounds}, '0);
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (s_out_valid) ov_seen++;
    end
    check("midrst.no_emit", ov_seen, 0);

    big_op("big_chain", {512{1'b1}}, '0, 1'b1, 128);
    big_op("big_zero", '0, '0, 1'b0, 0);
    for (int n = 0; n < 200; n++) begin
      ra = rnd512();
      rb = ($urandom_range(0, 3) == 0) ? ~ra : rnd512();
      big_op("big_rand", ra, rb, 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
